// File: rtl/demux_1_4_stream.sv
// 1:4 stream demultiplexer: routes one input word to one of four channels,
// each with a one-entry valid/ready holding register and a delivered-word counter.
module demux_1_4_stream #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
);

  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];
  logic [CNT_W-1:0] cnt_q  [4];
  logic [CNT_W-1:0] cnt_d  [4];
  logic [3:0]       vld_q;
  logic [3:0]       vld_d;
  logic [3:0]       wr;
  logic [3:0]       drn;
  logic             acc;

  // A full channel still accepts when its consumer drains in the same cycle,
  // which gives one word per cycle of pass-through.
  assign in_ready = !vld_q[sel] || out_ready[sel];
  assign acc      = in_valid && in_ready;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no latch is inferred.
    wr     = '0;
    drn    = '0;
    vld_d  = vld_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    for (int k = 0; k < 4; k++) begin
      wr[k]  = acc && (sel == 2'(k));
      drn[k] = vld_q[k] && out_ready[k];
      if (wr[k]) begin
        data_d[k] = d;
        vld_d[k]  = 1'b1;
      end else if (drn[k]) begin
        vld_d[k]  = 1'b0;
      end
      cnt_d[k] = cnt_q[k] + CNT_W'(drn[k]);
    end
  end

  // NOTE: state uses non-blocking assignments so all channels update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid = vld_q;
  assign y0   = data_q[0];
  assign y1   = data_q[1];
  assign y2   = data_q[2];
  assign y3   = data_q[3];
  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Self-checking bench for demux_1_4_stream: per-channel slot model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_demux_1_4_stream;

  logic       clk;
  logic       rst_n;
  logic [3:0] d;
  logic [1:0] sel;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] y0, y1, y2, y3;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] cnt0, cnt1, cnt2, cnt3;

  int n_checks = 0;
  int n_errors = 0;

  demux_1_4_stream #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .d(d), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .out_valid(out_valid), .out_ready(out_ready),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each channel is a slot that is either empty or holds one word,
  // plus a count of words handed to its consumer.
  int  m_word [4];
  bit  m_full [4];
  int  m_dlv  [4];

  function automatic void model_clear();
    for (int k = 0; k < 4; k++) begin
      m_word[k] = 0;
      m_full[k] = 0;
      m_dlv[k]  = 0;
    end
  endfunction

  always @(negedge rst_n) model_clear();

  always @(posedge clk) begin
    if (!rst_n) begin
      model_clear();
    end else begin
      bit taken;
      bit handed [4];
      taken = in_valid && (!m_full[sel] || out_ready[sel]);
      for (int k = 0; k < 4; k++) handed[k] = m_full[k] && out_ready[k];
      for (int k = 0; k < 4; k++) begin
        if (handed[k]) begin
          m_full[k] = 0;
          m_dlv[k]  = (m_dlv[k] + 1) % 256;
        end
      end
      if (taken) begin
        m_word[sel] = int'(d);
        m_full[sel] = 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] exp_vld;
    for (int k = 0; k < 4; k++) exp_vld[k] = m_full[k];
    check("mdl_out_valid", 32'(out_valid), 32'(exp_vld));
    check("mdl_in_ready", 32'(in_ready), 32'(!m_full[sel] || out_ready[sel]));
    check("mdl_y0", 32'(y0), m_word[0]);
    check("mdl_y1", 32'(y1), m_word[1]);
    check("mdl_y2", 32'(y2), m_word[2]);
    check("mdl_y3", 32'(y3), m_word[3]);
    check("mdl_cnt0", 32'(cnt0), m_dlv[0]);
    check("mdl_cnt1", 32'(cnt1), m_dlv[1]);
    check("mdl_cnt2", 32'(cnt2), m_dlv[2]);
    check("mdl_cnt3", 32'(cnt3), m_dlv[3]);
  end

  task automatic drive(input logic v, input logic [1:0] s, input logic [3:0] dd,
                       input logic [3:0] rdy);
    in_valid  = v;
    sel       = s;
    d         = dd;
    out_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_cnts(input string tag, input int c0, input int c1,
                            input int c2, input int c3);
    check({tag, "_cnt0"}, 32'(cnt0), c0);
    check({tag, "_cnt1"}, 32'(cnt1), c1);
    check({tag, "_cnt2"}, 32'(cnt2), c2);
    check({tag, "_cnt3"}, 32'(cnt3), c3);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 4'h0, 4'b0000);
    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_y0", 32'(y0), 32'h0);
    check("rst_y3", 32'(y3), 32'h0);
    check_cnts("rst", 0, 0, 0, 0);
    rst_n = 1'b1;

    // Scenario 1: single word to channel 2, drained the following cycle.
    drive(1'b1, 2'd2, 4'hA, 4'b1111);
    #1 check("s1_in_ready", 32'(in_ready), 32'h1);
    tick();
    check("s1_y2", 32'(y2), 32'hA);
    check("s1_out_valid", 32'(out_valid), 32'b0100);
    drive(1'b0, 2'd3, 4'hF, 4'b1111);
    tick();
    check("s1_out_valid_after", 32'(out_valid), 32'h0);
    check("s1_y2_hold", 32'(y2), 32'hA);
    check("s1_y3_idle", 32'(y3), 32'h0);
    check_cnts("s1", 0, 0, 1, 0);

    // Scenario 2: channel 1 stalls; channel 0 still accepts.
    drive(1'b1, 2'd1, 4'h3, 4'b0000);
    tick();
    check("s2_y1", 32'(y1), 32'h3);
    check("s2_out_valid", 32'(out_valid), 32'b0010);
    drive(1'b1, 2'd1, 4'h5, 4'b0000);
    #1 check("s2_in_ready_blocked", 32'(in_ready), 32'h0);
    tick();
    check("s2_y1_hold", 32'(y1), 32'h3);
    drive(1'b1, 2'd0, 4'h7, 4'b0000);
    #1 check("s2_in_ready_other", 32'(in_ready), 32'h1);
    tick();
    check("s2_y0", 32'(y0), 32'h7);
    check("s2_out_valid2", 32'(out_valid), 32'b0011);

    // Scenario 3: back-to-back pass-through on channel 3.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 2'd3, 4'(i), 4'b1000);
      #1 check("s3_in_ready", 32'(in_ready), 32'h1);
      tick();
      check("s3_y3", 32'(y3), i);
    end
    drive(1'b0, 2'd0, 4'h0, 4'b1000);
    tick();
    check_cnts("s3", 0, 0, 1, 4);
    check("s3_y1_stalled", 32'(y1), 32'h3);

    // Scenario 4: all four full, all drain together while channel 0 reloads.
    drive(1'b1, 2'd2, 4'h9, 4'b0000);
    tick();
    drive(1'b1, 2'd3, 4'hC, 4'b0000);
    tick();
    check("s4_all_full", 32'(out_valid), 32'b1111);
    drive(1'b1, 2'd0, 4'hF, 4'b1111);
    #1 check("s4_in_ready", 32'(in_ready), 32'h1);
    tick();
    check("s4_out_valid", 32'(out_valid), 32'b0001);
    check("s4_y0", 32'(y0), 32'hF);
    check_cnts("s4", 1, 1, 2, 5);
    drive(1'b0, 2'd0, 4'h0, 4'b0001);
    tick();
    check("s4_cnt0_drain", 32'(cnt0), 2);

    // Scenario 5: 256 deliveries on channel 1 wrap its counter back to its start.
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 2'd1, 4'(i), 4'b0010);
      tick();
    end
    check("s5_cnt1_wrap0", 32'(cnt1), 0);
    drive(1'b0, 2'd0, 4'h0, 4'b0010);
    tick();
    check_cnts("s5", 2, 1, 2, 5);

    // Scenario 6: asynchronous reset with channels 0 and 2 full.
    drive(1'b1, 2'd0, 4'h6, 4'b0000);
    tick();
    drive(1'b1, 2'd2, 4'h8, 4'b0000);
    tick();
    check("s6_pre_valid", 32'(out_valid), 32'b0101);
    drive(1'b0, 2'd0, 4'h0, 4'b0000);
    #1 rst_n = 1'b0;
    #1;
    check("s6_async_valid", 32'(out_valid), 32'h0);
    check("s6_async_y0", 32'(y0), 32'h0);
    check("s6_async_y2", 32'(y2), 32'h0);
    check_cnts("s6", 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    drive(1'b1, 2'd2, 4'hA, 4'b1111);
    tick();
    check("s6_y2", 32'(y2), 32'hA);
    check("s6_out_valid", 32'(out_valid), 32'b0100);
    drive(1'b0, 2'd0, 4'h0, 4'b1111);
    tick();
    check("s6_drained", 32'(out_valid), 32'h0);
    check_cnts("s6b", 0, 0, 1, 0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
